// File: rtl/gaplus_coin_ctrl.sv
// gaplus_coin_ctrl: frame-rate coin chute debounce, pending meter counts and
// round-robin scheduling of the shared coin-meter solenoid driver.
module gaplus_coin_ctrl #(
  parameter int DEB_FRAMES = 3,
  parameter int PULSE_ON   = 4,
  parameter int PULSE_OFF  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       VBLK,
  input  logic [1:0] COIN_RAW,
  input  logic [1:0] LOCKOUT,
  output logic [1:0] COIN_EV,
  output logic [1:0] METER,
  output logic [3:0] PEND0,
  output logic [3:0] PEND1,
  output logic       BUSY
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t     state, state_nx;
  logic       vblk_d, tick, ptr, ptr_nx, gsel;
  logic [3:0] fcnt, fcnt_nx;
  logic [1:0] deb, hit, acc, dec;
  logic [3:0] dcnt [2];
  logic [3:0] pend [2];
  assign tick  = VBLK & ~vblk_d;
  assign PEND0 = pend[0];
  assign PEND1 = pend[1];
  // ptr holds the last granted chute; it resets to 1 so chute 0 wins first
  assign gsel  = (|pend[0] && |pend[1]) ? ~ptr : |pend[1];
  always_comb begin
    hit = '0;
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      hit[i] = (COIN_RAW[i] != deb[i]) && (dcnt[i] == 4'(DEB_FRAMES - 1));
      acc[i] = tick & hit[i] & COIN_RAW[i] & ~LOCKOUT[i];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vblk_d  <= 1'b0;
      deb     <= '0;
      COIN_EV <= '0;
      for (int i = 0; i < 2; i++) begin
        dcnt[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      vblk_d <= VBLK;
      for (int i = 0; i < 2; i++) begin
        if (tick) begin
          dcnt[i]    <= (COIN_RAW[i] == deb[i] || hit[i]) ? 4'd0 : dcnt[i] + 4'd1;
          deb[i]     <= hit[i] ? COIN_RAW[i] : deb[i];
          COIN_EV[i] <= acc[i];
        end
        // an accept and a grant on the same tick cancel, even when saturated
        pend[i] <= (acc[i] & ~dec[i]) ? ((&pend[i]) ? pend[i] : pend[i] + 4'd1) :
                   (dec[i] & ~acc[i]) ? pend[i] - 4'd1 : pend[i];
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      fcnt  <= '0;
      ptr   <= 1'b1;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      ptr   <= ptr_nx;
    end
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    ptr_nx   = ptr;
    dec      = '0;
    if (tick)
      case (state)
        IDLE:
          if (|pend[0] || |pend[1]) begin
            ptr_nx   = gsel;
            dec      = gsel ? 2'b10 : 2'b01;
            fcnt_nx  = 4'(PULSE_ON);
            state_nx = ON;
          end
        ON: begin
          fcnt_nx = fcnt - 4'd1;
          if (fcnt == 4'd1) begin
            fcnt_nx  = 4'(PULSE_OFF);
            state_nx = OFF;
          end
        end
        OFF: begin
          fcnt_nx  = fcnt - 4'd1;
          state_nx = (fcnt == 4'd1) ? IDLE : OFF;
        end
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    METER = (state == ON) ? (ptr ? 2'b10 : 2'b01) : 2'b00;
    BUSY  = state != IDLE;
  end
endmodule

// File: tb/tb_gaplus_coin_ctrl.sv
// tb_gaplus_coin_ctrl: directed checks of debounce, lockout, meter scheduling and pending-count saturation
module tb_gaplus_coin_ctrl;
  logic       clk, reset_n, VBLK;
  logic [1:0] raw, lock, ev, meter;
  logic [3:0] p0, p1;
  logic       busy;
  logic [1:0] raw_s, ev_s, meter_s;
  logic [3:0] p0_s, p1_s;
  logic       busy_s;
  int total = 0, bad = 0, waited = 0;
  int m0c = 0, m1c = 0, e0c = 0;
  logic m0p = 0, m1p = 0, e0p = 0;
  gaplus_coin_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .VBLK(VBLK), .COIN_RAW(raw), .LOCKOUT(lock),
    .COIN_EV(ev), .METER(meter), .PEND0(p0), .PEND1(p1), .BUSY(busy));
  gaplus_coin_ctrl #(.DEB_FRAMES(1), .PULSE_ON(15), .PULSE_OFF(15)) u_sat (
    .clk(clk), .reset_n(reset_n), .VBLK(VBLK), .COIN_RAW(raw_s), .LOCKOUT(2'b00),
    .COIN_EV(ev_s), .METER(meter_s), .PEND0(p0_s), .PEND1(p1_s), .BUSY(busy_s));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    m0p <= meter_s[0];
    m1p <= meter_s[1];
    e0p <= ev_s[0];
    if (meter_s[0] && !m0p) m0c <= m0c + 1;
    if (meter_s[1] && !m1p) m1c <= m1c + 1;
    if (ev_s[0] && !e0p) e0c <= e0c + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic frame();
    @(negedge clk) VBLK = 1;
    @(negedge clk) VBLK = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask
  initial begin
    reset_n = 0; VBLK = 0; raw = 0; lock = 0; raw_s = 0;
    raw = 2'b01;
    frames(4);
    chk("rst_ev", ev, 2'b00);
    chk("rst_pend0", p0, 4'd0);
    chk("rst_meter", meter, 2'b00);
    chk("rst_busy", busy, 1'b0);
    raw = 2'b00;
    @(negedge clk) reset_n = 1;
    raw = 2'b01;
    frames(2);
    raw = 2'b00;
    frame();
    chk("glitch_ev", ev, 2'b00);
    chk("glitch_pend0", p0, 4'd0);
    raw = 2'b01;
    frames(2);
    chk("deb2_ev", ev, 2'b00);
    frame();
    chk("coin0_ev", ev, 2'b01);
    chk("coin0_pend", p0, 4'd1);
    chk("coin0_idle", busy, 1'b0);
    @(negedge clk);
    chk("coin0_ev_hold", ev, 2'b01);
    raw = 2'b00;
    frame();
    chk("coin0_ev_clr", ev, 2'b00);
    chk("grant0_meter", meter, 2'b01);
    chk("grant0_pend", p0, 4'd0);
    chk("grant0_busy", busy, 1'b1);
    frames(8);
    chk("drain0_busy", busy, 1'b0);
    raw = 2'b10;
    frames(3);
    chk("coin1_ev", ev, 2'b10);
    chk("coin1_pend", p1, 4'd1);
    raw = 2'b00;
    frame();
    chk("grant1_meter", meter, 2'b10);
    chk("grant1_pend", p1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      frame();
      chk("pulse1_on", meter, 2'b10);
    end
    frame();
    chk("pulse1_off", meter, 2'b00);
    chk("pulse1_off_busy", busy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      frame();
      chk("gap1_busy", busy, 1'b1);
    end
    frame();
    chk("gap1_done", busy, 1'b0);
    @(negedge clk); #2 reset_n = 0;
    @(negedge clk) reset_n = 1;
    raw = 2'b11;
    frames(3);
    chk("both_ev", ev, 2'b11);
    chk("both_p0", p0, 4'd1);
    chk("both_p1", p1, 4'd1);
    raw = 2'b00;
    frame();
    chk("rr_first", meter, 2'b01);
    chk("rr_p0", p0, 4'd0);
    chk("rr_p1_wait", p1, 4'd1);
    for (int k = 1; k <= 7; k++) begin
      frame();
      chk("rr_pulse0", meter, (k <= 3) ? 2'b01 : 2'b00);
    end
    frame();
    chk("rr_gap_meter", meter, 2'b00);
    chk("rr_gap_busy", busy, 1'b0);
    frame();
    chk("rr_second", meter, 2'b10);
    chk("rr_p1", p1, 4'd0);
    frames(8);
    lock = 2'b01;
    raw = 2'b01;
    frames(3);
    chk("lock_ev", ev, 2'b00);
    chk("lock_pend", p0, 4'd0);
    chk("lock_busy", busy, 1'b0);
    lock = 2'b00;
    raw = 2'b00;
    frames(3);
    raw = 2'b01;
    frames(3);
    chk("unlock_ev", ev, 2'b01);
    chk("unlock_pend", p0, 4'd1);
    raw = 2'b00;
    frame();
    chk("unlock_grant", meter, 2'b01);
    raw = 2'b10;
    frames(3);
    chk("queued_p1", p1, 4'd1);
    chk("queued_meter", meter, 2'b01);
    @(negedge clk); #2 reset_n = 0;
    #1;
    chk("arst_meter", meter, 2'b00);
    chk("arst_p1", p1, 4'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ev", ev, 2'b00);
    raw = 2'b00;
    @(negedge clk) reset_n = 1;
    for (int t = 1; t <= 34; t++) begin
      raw_s = (t == 1) ? 2'b10 : (t % 2 == 0) ? 2'b01 : 2'b00;
      frame();
      if (t == 2) begin
        chk("sat_grant1", meter_s, 2'b10);
        chk("sat_p0_first", p0_s, 4'd1);
      end
      if (t == 30) chk("sat_p0_full", p0_s, 4'd15);
      if (t == 32) begin
        chk("sat_p0_lost", p0_s, 4'd15);
        chk("sat_ev_lost", ev_s, 2'b01);
      end
      if (t == 33) begin
        chk("sat_grant0", meter_s, 2'b01);
        chk("sat_p0_dec", p0_s, 4'd14);
      end
      if (t == 34) begin
        chk("sat_p0_refill", p0_s, 4'd15);
        chk("sat_ev_last", ev_s, 2'b01);
      end
    end
    raw_s = 2'b00;
    for (waited = 0; waited < 700 && !(busy_s == 1'b0 && p0_s == 4'd0); waited++) frame();
    chk("sat_drain_timeout", waited < 700, 1'b1);
    chk("sat_drain_busy", busy_s, 1'b0);
    chk("sat_drain_p0", p0_s, 4'd0);
    frame();
    chk("sat_m0_pulses", m0c, 16);
    chk("sat_m1_pulses", m1c, 1);
    chk("sat_ev_pulses", e0c, 17);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
